mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-master front end for the single-port 16-bit Memory block (MA/MW/MWD in, MD out).
- Sits directly upstream of Memory. Arbitrates between the instruction-fetch port (I) and the load/store port (D).
- Drives one registered memory command per cycle and routes the returning MD word back to the master that issued the read.

Parameters:
- AW, 16, address width (MA)
- DW, 16, data width (MWD/MD)
- RD_LAT, 1, cycles from the clock edge that samples MA until MD is valid (≥1)

Ports:
- CLK  in  1  system clock, all state updates on rising edge
- RST  in  1  synchronous active-high reset
- I_REQ  in  1  fetch read request
- I_ADDR  in  AW  fetch address
- I_ACK  out  1  combinational grant; request taken at this edge when I_REQ&&I_ACK
- I_RDATA  out  DW  fetch read data
- I_RVALID  out  1  one-cycle pulse, I_RDATA valid
- D_REQ  in  1  load/store request
- D_WE  in  1  1=store, 0=load
- D_ADDR  in  AW  load/store address
- D_WDATA  in  DW  store data
- D_ACK  out  1  combinational grant
- D_RDATA  out  DW  load data
- D_RVALID  out  1  one-cycle pulse, D_RDATA valid (loads only)
- MA  out  AW  memory address (registered)
- MW  out  1  memory write enable (registered)
- MWD  out  DW  memory write data (registered)
- MD  in  DW  memory read data

Behaviour:
- Reset values: MA=0, MW=0, MWD=0, I_RDATA=0, D_RDATA=0, I_RVALID=0, D_RVALID=0. Tag pipeline cleared. Priority pointer = D.
- Grant is combinational, at most one ACK per cycle:
  - only one REQ: that port is granted;
  - both REQ: the port named by the priority pointer (fixed D unless ARB_RR_EN);
  - no REQ: both ACK=0.
- Accept edge E (REQ&&ACK sampled): MA<=addr, MW<=D_WE (0 for I), MWD<=D_WDATA (held for I).
- No accept at edge: MW<=0 and MA/MWD hold. MW never stays high for more than one cycle per accepted store.
- Read path:
  - the tag shift register, depth RD_LAT+1, records {valid, src} at each accept of a read;
  - at edge E+RD_LAT+1 the tagged port's RDATA<=MD and its RVALID pulses high for exactly one cycle;
  - RDATA holds until the next response to that port.
- Latency: a read accepted at edge E returns RVALID after edge E+2 (RD_LAT=1). Stores produce no RVALID.
- Throughput: one command per cycle, back-to-back, any mix of masters.
- Responses return in acceptance order. A load after a store to the same address returns the stored value; a store after a load does not disturb the earlier load.
- RST asserted mid-flight: all in-flight tags are discarded, no RVALID is produced for them after reset, and MW=0 on the next cycle.
- Address wrap: MA passes through unmodified (0xFFFF is legal, no increment logic).

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin. After each contended grant (both REQ high), the pointer flips to the other port. Uncontended grants do not move the pointer.
- Undefined: D has fixed priority and I waits while D_REQ stays high. The pointer register is not generated.

Test Plan:
- Reset, then I_REQ=1, I_ADDR=0x0000 for one cycle -> I_ACK=1 that cycle; MA=0x0000, MW=0 next cycle; I_RVALID pulses 2 edges after accept with I_RDATA=Mem[0]; D_RVALID stays 0.
- D store 0x001F to addr 5, then D load addr 5 on the next cycle -> MW=1 for exactly one cycle; D_RVALID pulses once with D_RDATA=0x001F.
- I_REQ and D_REQ both held high, reads to 1 and 2, for 4 cycles -> without ARB_RR_EN: D_ACK=1 every cycle and I_ACK=0. With ARB_RR_EN: grants alternate D,I,D,I and responses return in that order.
- I reads at 1, 2, 7 on consecutive cycles -> three I_RVALID pulses on consecutive cycles with data Mem[1], Mem[2], Mem[7] in order.
- Load accepted, RST asserted on the following edge -> no D_RVALID ever appears; all outputs at reset values; the next request is serviced normally.
- RD_LAT=2 build, single I read at 0xFFFF -> I_RVALID exactly 3 edges after accept; MA=0xFFFF with no wrap.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (instruction fetch I, load/store D) front end for a
// single-port synchronous memory. One registered command per cycle goes to
// the memory; read data is steered back to the issuing master using a
// {valid, src} tag pipeline that tracks the memory's read latency.
// Optional feature: define ARB_RR_EN for round-robin arbitration on
// contention; otherwise D has fixed priority over I.
module mem_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          I_REQ,
  input  logic [AW-1:0] I_ADDR,
  output logic          I_ACK,
  output logic [DW-1:0] I_RDATA,
  output logic          I_RVALID,
  input  logic          D_REQ,
  input  logic          D_WE,
  input  logic [AW-1:0] D_ADDR,
  input  logic [DW-1:0] D_WDATA,
  output logic          D_ACK,
  output logic [DW-1:0] D_RDATA,
  output logic          D_RVALID,
  output logic [AW-1:0] MA,
  output logic          MW,
  output logic [DW-1:0] MWD,
  input  logic [DW-1:0] MD
);

  logic          d_first;
  logic          i_gnt, d_gnt, rd_acc;
  logic [AW-1:0] ma_q, ma_d;
  logic          mw_q, mw_d;
  logic [DW-1:0] mwd_q, mwd_d;
  logic [RD_LAT:0] tag_vld_q, tag_vld_d;
  logic [RD_LAT:0] tag_src_q, tag_src_d;  // 1 = D, 0 = I
  logic          resp_vld, resp_src;
  logic          i_rvalid_q, d_rvalid_q;
  logic [DW-1:0] i_rdata_q, d_rdata_q;

`ifdef ARB_RR_EN
  logic prio_q, prio_d;  // 1 = D wins the next contended cycle

  // Pointer flips only when both masters compete for the slot
  always_comb begin
    prio_d = prio_q;
    if (I_REQ && D_REQ) prio_d = ~prio_q;
  end

  // Priority pointer register, resets to D
  always_ff @(posedge CLK) begin
    if (RST) prio_q <= 1'b1;
    else     prio_q <= prio_d;
  end

  assign d_first = prio_q;
`else
  assign d_first = 1'b1;
`endif

  // Combinational grant: at most one ACK per cycle
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (D_REQ && (!I_REQ || d_first)) d_gnt = 1'b1;
    else if (I_REQ)                   i_gnt = 1'b1;
  end

  assign I_ACK  = i_gnt;
  assign D_ACK  = d_gnt;
  assign rd_acc = i_gnt | (d_gnt & ~D_WE);

  // Next memory command and tag pipeline contents
  always_comb begin
    ma_d      = ma_q;
    mw_d      = 1'b0;
    mwd_d     = mwd_q;
    tag_vld_d = {tag_vld_q[RD_LAT-1:0], rd_acc};
    tag_src_d = {tag_src_q[RD_LAT-1:0], d_gnt};
    if (d_gnt) begin
      ma_d  = D_ADDR;
      mw_d  = D_WE;
      mwd_d = D_WDATA;
    end else if (i_gnt) begin
      ma_d  = I_ADDR;
    end
  end

  // The oldest tag lines up with MD being valid for its read
  assign resp_vld = tag_vld_q[RD_LAT];
  assign resp_src = tag_src_q[RD_LAT];

  // Command, tag and response registers; reset drops all in-flight reads
  always_ff @(posedge CLK) begin
    if (RST) begin
      ma_q       <= '0;
      mw_q       <= 1'b0;
      mwd_q      <= '0;
      tag_vld_q  <= '0;
      tag_src_q  <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      ma_q       <= ma_d;
      mw_q       <= mw_d;
      mwd_q      <= mwd_d;
      tag_vld_q  <= tag_vld_d;
      tag_src_q  <= tag_src_d;
      i_rvalid_q <= resp_vld & ~resp_src;
      d_rvalid_q <= resp_vld &  resp_src;
      if (resp_vld && !resp_src) i_rdata_q <= MD;
      if (resp_vld &&  resp_src) d_rdata_q <= MD;
    end
  end

  assign MA       = ma_q;
  assign MW       = mw_q;
  assign MWD      = mwd_q;
  assign I_RVALID = i_rvalid_q;
  assign I_RDATA  = i_rdata_q;
  assign D_RVALID = d_rvalid_q;
  assign D_RDATA  = d_rdata_q;

endmodule
